// File: rtl/nx_node_pkg.sv
// nx_node_pkg: sizes, instruction layout and FSM states for the node core.
// Instr word (MSB..LSB): truth[7:0] src_a src_b src_c tgt_reg out_en out_idx.
package nx_node_pkg;

  localparam int INPUTS      = 8;
  localparam int REGISTERS   = 8;
  localparam int OUTPUTS     = 8;
  localparam int INSTR_DEPTH = 64;

  localparam int SEL_N  = (INPUTS + OUTPUTS) > REGISTERS ?
                          (INPUTS + OUTPUTS) : REGISTERS;
  localparam int SEL_W  = $clog2(SEL_N);
  localparam int ADDR_W = $clog2(INSTR_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int IN_W   = $clog2(INPUTS);
  localparam int REG_W  = $clog2(REGISTERS);
  localparam int OUT_W  = $clog2(OUTPUTS);

  typedef struct packed {
    logic             ip;
    logic [SEL_W-1:0] idx;
  } nx_src_t;

  typedef struct packed {
    logic [7:0]       truth;
    nx_src_t          src_a;
    nx_src_t          src_b;
    nx_src_t          src_c;
    logic [SEL_W-1:0] tgt_reg;
    logic             out_en;
    logic [SEL_W-1:0] out_idx;
  } nx_instr_t;

  localparam int INSTR_W = $bits(nx_instr_t);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COMMIT
  } nx_node_state_t;

  // 3-input LUT; a is the MSB of the select
  function automatic logic nx_lut(
    input logic [7:0] truth,
    input logic       a,
    input logic       b,
    input logic       c
  );
    return truth[{a, b, c}];
  endfunction

endpackage

// File: rtl/nx_node_imem.sv
// nx_node_imem: INSTR_DEPTH x INSTR_W instruction store, no reset.
// Ports: clk, we/waddr/wdata sync write, raddr -> rdata combinational read.
module nx_node_imem
  import nx_node_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [INSTR_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nx_node_exec.sv
// nx_node_exec: sequential truth-table node core (IDLE->RUN->COMMIT).
// Ports: clk, rst (sync, high), trigger/inputs/num_instr in, imem load
// port, o_busy/o_done/o_outputs/o_load_err out.
// Option NX_NODE_LOOPBACK_EN: ip-source indices past the inputs read a
// snapshot of the outputs taken with the input snapshot.
module nx_node_exec
  import nx_node_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_trigger,
  input  logic [INPUTS-1:0]  i_inputs,
  input  logic [CNT_W-1:0]   i_num_instr,
  input  logic               i_load_en,
  input  logic [ADDR_W-1:0]  i_load_addr,
  input  logic [INSTR_W-1:0] i_load_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [OUTPUTS-1:0] o_outputs,
  output logic               o_load_err
);

  nx_node_state_t state, state_next;

  logic [ADDR_W-1:0]    pc;
  logic [CNT_W-1:0]     count;
  logic [INPUTS-1:0]    snap;
  logic [REGISTERS-1:0] regs;
  logic [OUTPUTS-1:0]   shadow;
  logic                 pending;
  logic [OUTPUTS-1:0]   loop_view;

`ifdef NX_NODE_LOOPBACK_EN
  logic [OUTPUTS-1:0]   loop_snap;
  assign loop_view = loop_snap;
`else
  assign loop_view = '0;
`endif

  logic [INSTR_W-1:0] instr_word;
  nx_instr_t          instr;
  logic               res;
  logic [CNT_W-1:0]   num;
  logic               num_zero;
  logic               last;
  logic               start;

  nx_node_imem u_imem (
    .clk   (clk),
    .we    (i_load_en && (state == IDLE)),
    .waddr (i_load_addr),
    .wdata (i_load_data),
    .raddr (pc),
    .rdata (instr_word)
  );

  function automatic logic src_bit(
    input nx_src_t              s,
    input logic [INPUTS-1:0]    sn,
    input logic [OUTPUTS-1:0]   lp,
    input logic [REGISTERS-1:0] rf
  );
    logic b;
    b = 1'b0;
    if (s.ip) begin
      if (s.idx < SEL_W'(INPUTS))
        b = sn[s.idx[IN_W-1:0]];
      else if (s.idx < SEL_W'(INPUTS + OUTPUTS))
        b = lp[OUT_W'(s.idx - SEL_W'(INPUTS))];
    end else if (s.idx < SEL_W'(REGISTERS)) begin
      b = rf[s.idx[REG_W-1:0]];
    end
    return b;
  endfunction

  assign instr = instr_word;
  assign res   = nx_lut(instr.truth,
                        src_bit(instr.src_a, snap, loop_view, regs),
                        src_bit(instr.src_b, snap, loop_view, regs),
                        src_bit(instr.src_c, snap, loop_view, regs));

  assign num = (i_num_instr > CNT_W'(INSTR_DEPTH)) ?
               CNT_W'(INSTR_DEPTH) : i_num_instr;
  assign num_zero = (num == '0);
  assign last     = (({1'b0, pc} + CNT_W'(1)) == count);

  // COMMIT restarts directly when a trigger was seen during the run
  assign start = ((state == IDLE) && i_trigger) ||
                 ((state == COMMIT) && (pending || i_trigger));

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = num_zero ? COMMIT : RUN;
      RUN:     if (last)  state_next = COMMIT;
      COMMIT:  state_next = start ? (num_zero ? COMMIT : RUN) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      count      <= '0;
      snap       <= '0;
      regs       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      o_outputs  <= '0;
      o_done     <= 1'b0;
      o_load_err <= 1'b0;
`ifdef NX_NODE_LOOPBACK_EN
      loop_snap  <= '0;
`endif
    end else begin
      o_done     <= 1'b0;
      o_load_err <= i_load_en && (state != IDLE);
      if (start) begin
        snap    <= i_inputs;
        shadow  <= '0;
        count   <= num;
        pc      <= '0;
        pending <= 1'b0;
`ifdef NX_NODE_LOOPBACK_EN
        // back-to-back: o_outputs is only now receiving shadow
        loop_snap <= (state == COMMIT) ? shadow : o_outputs;
`endif
      end else if (state == RUN) begin
        pc <= pc + ADDR_W'(1);
        if (i_trigger) pending <= 1'b1;
        if (instr.tgt_reg < SEL_W'(REGISTERS))
          regs[instr.tgt_reg[REG_W-1:0]] <= res;
        if (instr.out_en && (instr.out_idx < SEL_W'(OUTPUTS)))
          shadow[instr.out_idx[OUT_W-1:0]] <= res;
      end
      if (state == COMMIT) begin
        o_outputs <= shadow;
        o_done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nx_node_exec.sv
// tb_nx_node_exec: directed + randomized bench for nx_node_exec with a
// behavioural model of the program semantics.
`timescale 1ns/1ps
module tb_nx_node_exec;
  import nx_node_pkg::*;

`ifdef NX_NODE_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               i_trigger;
  logic [7:0]         i_inputs;
  logic [6:0]         i_num_instr;
  logic               i_load_en;
  logic [5:0]         i_load_addr;
  logic [31:0]        i_load_data;
  logic               o_busy;
  logic               o_done;
  logic [7:0]         o_outputs;
  logic               o_load_err;

  int n_tests = 0;
  int n_fail  = 0;

  bit [31:0] m_imem [64];
  bit [7:0]  m_regs;
  bit [7:0]  m_out;

  always #5 clk = ~clk;

  nx_node_exec dut (
    .clk         (clk),
    .rst         (rst),
    .i_trigger   (i_trigger),
    .i_inputs    (i_inputs),
    .i_num_instr (i_num_instr),
    .i_load_en   (i_load_en),
    .i_load_addr (i_load_addr),
    .i_load_data (i_load_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_outputs   (o_outputs),
    .o_load_err  (o_load_err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] mk(bit [7:0] t, bit [4:0] a, bit [4:0] b,
                                   bit [4:0] c, bit [3:0] tg, bit oe,
                                   bit [3:0] oi);
    return {t, a, b, c, tg, oe, oi};
  endfunction

  function automatic bit msrc(bit [4:0] s, bit [7:0] sn, bit [7:0] lp);
    int idx;
    idx = int'(s[3:0]);
    if (s[4]) begin
      if (idx < 8) return sn[idx];
      if (LB && idx < 16) return lp[idx-8];
      return 1'b0;
    end
    if (idx < 8) return m_regs[idx];
    return 1'b0;
  endfunction

  // runs n instructions of the model program, returns committed outputs
  function automatic bit [7:0] model_run(bit [7:0] sn, int n, bit [7:0] lp);
    bit [7:0]  sh;
    bit [31:0] w;
    bit [7:0]  t;
    int        sel;
    int        tg;
    int        oi;
    bit        r;
    sh = 8'h00;
    for (int p = 0; p < n; p++) begin
      w   = m_imem[p];
      t   = w[31:24];
      sel = 4 * int'(msrc(w[23:19], sn, lp)) +
            2 * int'(msrc(w[18:14], sn, lp)) +
                int'(msrc(w[13:9],  sn, lp));
      r   = t[sel];
      tg  = int'(w[8:5]);
      oi  = int'(w[3:0]);
      if (tg < 8) m_regs[tg] = r;
      if (w[4] && oi < 8) sh[oi] = r;
    end
    return sh;
  endfunction

  task automatic load(input int addr, input bit [31:0] data);
    i_load_en   = 1'b1;
    i_load_addr = 6'(addr);
    i_load_data = data;
    @(posedge clk); #1;
    i_load_en = 1'b0;
    m_imem[addr] = data;
  endtask

  task automatic do_run(input string tag, input bit [7:0] inp, input int n,
                        input int bad_load_at);
    int       nc;
    int       lat;
    bit [7:0] exp;
    nc  = (n > 64) ? 64 : n;
    exp = model_run(inp, nc, m_out);
    i_inputs    = inp;
    i_num_instr = 7'(n);
    i_trigger   = 1'b1;
    @(posedge clk); #1;
    i_trigger = 1'b0;
    lat = 0;
    while (!o_done && lat < 200) begin
      if (lat == bad_load_at) begin
        i_load_en   = 1'b1;
        i_load_addr = 6'd0;
        i_load_data = ~m_imem[0];
      end
      @(posedge clk); #1;
      lat++;
      if (i_load_en) begin
        i_load_en = 1'b0;
        check({tag, "_lerr"}, 32'(o_load_err), 32'd1);
      end
    end
    check({tag, "_lat"}, lat, nc + 1);
    check({tag, "_out"}, 32'(o_outputs), 32'(exp));
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    m_out = exp;
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(o_done), 32'd0);
  endtask

  function automatic bit [31:0] rnd_instr();
    return $urandom;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit [7:0] a_in;
    bit [7:0] b_in;
    bit [7:0] exp_a;
    bit [7:0] exp_b;
    int       dones;
    bit       seen;
    int       len;
    int       n;
    int       bad;

    rst = 1'b1;
    i_trigger = 1'b0;
    i_inputs = 8'h00;
    i_num_instr = 7'd0;
    i_load_en = 1'b0;
    i_load_addr = 6'd0;
    i_load_data = 32'd0;
    m_regs = 8'h00;
    m_out = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_out", 32'(o_outputs), 32'd0);
    check("rst_lerr", 32'(o_load_err), 32'd0);

    for (int i = 0; i < 64; i++) load(i, rnd_instr());
    check("idle_lerr", 32'(o_load_err), 32'd0);

    // 1: AND of in0..in2 to out3
    load(0, mk(8'h80, 5'h10, 5'h11, 5'h12, 4'hF, 1'b1, 4'd3));
    do_run("t1", 8'h07, 1, -1);
    check("t1_const", 32'(o_outputs), 32'h08);

    // 2: register chain r0=in0, r1=~r0, out0=r1
    load(0, mk(8'hF0, 5'h10, 5'h0F, 5'h0F, 4'd0, 1'b0, 4'd0));
    load(1, mk(8'h0F, 5'h00, 5'h0F, 5'h0F, 4'd1, 1'b0, 4'd0));
    load(2, mk(8'hF0, 5'h01, 5'h0F, 5'h0F, 4'hF, 1'b1, 4'd0));
    do_run("t2", 8'($urandom) | 8'h01, 3, -1);
    check("t2_bit0", 32'(o_outputs[0]), 32'd0);

    // 3: all ones, then an empty run clears the outputs
    for (int i = 0; i < 8; i++)
      load(i, mk(8'hFF, 5'h0F, 5'h0F, 5'h0F, 4'hF, 1'b1, 4'(i)));
    do_run("t3a", 8'($urandom), 8, -1);
    check("t3a_const", 32'(o_outputs), 32'hFF);
    do_run("t3b", 8'($urandom), 0, -1);
    check("t3b_const", 32'(o_outputs), 32'h00);

    // 4: three triggers during a 5-instr run coalesce into one rerun
    for (int i = 0; i < 5; i++) load(i, rnd_instr());
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    exp_a = model_run(a_in, 5, m_out);
    exp_b = model_run(b_in, 5, exp_a);
    i_inputs = a_in;
    i_num_instr = 7'd5;
    i_trigger = 1'b1;
    dones = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (o_done) begin
        dones++;
        if (dones == 1) begin
          check("t4_t1", c, 6);
          check("t4_o1", 32'(o_outputs), 32'(exp_a));
        end else if (dones == 2) begin
          check("t4_t2", c, 12);
          check("t4_o2", 32'(o_outputs), 32'(exp_b));
        end
      end
      i_trigger = (c + 1 == 1) || (c + 1 == 3) || (c + 1 == 5);
      i_inputs  = (c + 1 == 6) ? b_in : 8'($urandom);
    end
    i_trigger = 1'b0;
    check("t4_dones", dones, 2);
    m_out = exp_b;

    // 5: load while busy is rejected; imem content survives
    do_run("t5a", 8'($urandom), 5, 1);
    do_run("t5b", 8'($urandom), 5, -1);

    // 5: fill regs, copy them out, then reset mid-run
    for (int i = 0; i < 8; i++)
      load(i, mk(8'hFF, 5'h0F, 5'h0F, 5'h0F, 4'(i), 1'b0, 4'd0));
    do_run("t5r", 8'($urandom), 8, -1);
    for (int i = 0; i < 8; i++)
      load(i, mk(8'hF0, 5'(i), 5'h0F, 5'h0F, 4'hF, 1'b1, 4'(i)));
    do_run("t5c", 8'($urandom), 8, -1);
    check("t5c_const", 32'(o_outputs), 32'hFF);
    i_num_instr = 7'd8;
    i_trigger = 1'b1;
    @(posedge clk); #1;
    i_trigger = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_regs = 8'h00;
    m_out = 8'h00;
    seen = o_done;
    check("t5_rout", 32'(o_outputs), 32'd0);
    check("t5_rbusy", 32'(o_busy), 32'd0);
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | o_done;
    end
    check("t5_nodone", 32'(seen), 32'd0);
    do_run("t5z", 8'($urandom), 8, -1);
    check("t5z_const", 32'(o_outputs), 32'h00);

    // 6: out0 = ~loop0 over repeated runs
    load(0, mk(8'h0F, 5'h18, 5'h0F, 5'h0F, 4'hF, 1'b1, 4'd0));
    for (int k = 0; k < 3; k++) begin
      do_run("t6", 8'($urandom), 1, -1);
      check("t6_bit0", 32'(o_outputs[0]),
            LB ? 32'((k % 2) == 0) : 32'd1);
    end

    // randomized programs
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) load(i, rnd_instr());
      n = len;
      if ($urandom_range(0, 7) == 0) n = 0;
      else if ($urandom_range(0, 9) == 0) n = $urandom_range(65, 127);
      bad = (n >= 2 && $urandom_range(0, 3) == 0) ? 1 : -1;
      do_run("rnd", 8'($urandom), n, bad);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
